// File: rtl/projcalculadoranios_nios2_qsys_0_oci_pkg.sv
// Shared definitions for the OCI branch-trace (DCT) packer.
//   DCT_SLOTS / CODE_W : packet geometry (codes per packet, bits per code)
//   dct_code_e         : branch-outcome code encodings
//   oci_state_e        : packer control state encoding
package projcalculadoranios_nios2_qsys_0_oci_pkg;

  localparam int DCT_SLOTS = 15;
  localparam int CODE_W    = 2;

  typedef enum logic [1:0] {
    CODE_RSVD = 2'b00,  // reserved, never stored
    CODE_NT   = 2'b01,  // not taken
    CODE_TK   = 2'b10,  // taken
    CODE_IND  = 2'b11   // indirect
  } dct_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ENDED = 2'd3
  } oci_state_e;

endpackage

// File: rtl/projcalculadoranios_nios2_qsys_0_oci_dct_accum.sv
// DCT accumulator: collects codes slot by slot until the packer moves them out.
//   clk, reset  : clock, synchronous active-high reset
//   wr_en_i     : store wr_code_i this cycle
//   wr_code_i   : code to store
//   clr_i       : contents are being transferred out; start a fresh packet
//   acc_buf_o   : packed slots, slot k at [CW*k +: CW], unused slots zero
//   acc_count_o : number of filled slots
module projcalculadoranios_nios2_qsys_0_oci_dct_accum #(
  parameter  int SLOTS = 15,
  parameter  int CW    = 2,
  localparam int CNT_W = $clog2(SLOTS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en_i,
  input  logic [CW-1:0]       wr_code_i,
  input  logic                clr_i,
  output logic [SLOTS*CW-1:0] acc_buf_o,
  output logic [CNT_W-1:0]    acc_count_o
);

  logic [SLOTS-1:0][CW-1:0] slot_q, slot_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  // On a clear the write lands in slot 0 of the emptied buffer; otherwise in
  // the next free slot. Cleared slots go to zero so unused slots read as zero.
  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    logic hit;
    assign hit = wr_en_i && (clr_i ? (k == 0) : (cnt_q == CNT_W'(k)));
    assign slot_d[k] = hit   ? wr_code_i :
                       clr_i ? '0        : slot_q[k];
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)        cnt_d = wr_en_i ? CNT_W'(1) : '0;
    else if (wr_en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= '0;
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
    end
  end

  assign acc_buf_o   = slot_q;
  assign acc_count_o = cnt_q;

endmodule

// File: rtl/projcalculadoranios_nios2_qsys_0_oci_dct_packer.sv
// OCI branch-trace packer: packs 2-bit branch outcomes into DCT_SLOTS-code
// packets, hands them to a consumer through a one-entry output register, and
// sequences the end-of-test drain.
//   clk, reset        : clock, synchronous active-high reset
//   trc_on            : trace enable
//   dct_valid/code    : incoming branch outcome
//   end_req           : pulse requesting end-of-test drain
//   pkt_ready         : consumer takes the packet this cycle
//   dct_buffer/count  : packet contents and number of valid slots
//   pkt_valid         : output register holds a packet
//   overflow          : sticky, a code was dropped
//   test_ending       : draining
//   test_has_ended    : drain complete
module projcalculadoranios_nios2_qsys_0_oci_dct_packer #(
  parameter  int DCT_SLOTS = projcalculadoranios_nios2_qsys_0_oci_pkg::DCT_SLOTS,
  parameter  int CODE_W    = projcalculadoranios_nios2_qsys_0_oci_pkg::CODE_W,
  localparam int BUF_W     = DCT_SLOTS * CODE_W,
  localparam int CNT_W     = $clog2(DCT_SLOTS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trc_on,
  input  logic              dct_valid,
  input  logic [CODE_W-1:0] dct_code,
  input  logic              end_req,
  input  logic              pkt_ready,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              pkt_valid,
  output logic              overflow,
  output logic              test_ending,
  output logic              test_has_ended
);

  import projcalculadoranios_nios2_qsys_0_oci_pkg::*;

  oci_state_e       state_q, state_d;
  logic [BUF_W-1:0] acc_buf;
  logic [CNT_W-1:0] acc_count;
  logic [BUF_W-1:0] buf_q;
  logic [CNT_W-1:0] cnt_q;
  logic             vld_q, ovf_q;

  logic acc_full, acc_empty, out_free, cand, xfer, accept, drop;

  assign acc_full  = (acc_count == CNT_W'(DCT_SLOTS));
  assign acc_empty = (acc_count == '0);
  assign out_free  = !vld_q || pkt_ready;

  // All-zero code is the reserved encoding: ignored, never an overflow.
  assign cand = dct_valid && trc_on && (state_q == ST_RUN) && (|dct_code);

  // Full packets move out in any state; partial ones only while draining.
  assign xfer = out_free && (acc_full || ((state_q == ST_DRAIN) && !acc_empty));

  // A code aimed at a full accumulator survives only if that accumulator is
  // being emptied on the same edge.
  assign accept = cand && (!acc_full || xfer);
  assign drop   = cand && acc_full && !xfer;

  projcalculadoranios_nios2_qsys_0_oci_dct_accum #(
    .SLOTS (DCT_SLOTS),
    .CW    (CODE_W)
  ) u_accum (
    .clk         (clk),
    .reset       (reset),
    .wr_en_i     (accept),
    .wr_code_i   (dct_code),
    .clr_i       (xfer),
    .acc_buf_o   (acc_buf),
    .acc_count_o (acc_count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (end_req) state_d = ST_DRAIN;
                else if (trc_on) state_d = ST_RUN;
      ST_RUN:   if (end_req) state_d = ST_DRAIN;
                else if (!trc_on) state_d = ST_IDLE;
      // Done once nothing is buffered and the last packet has been taken.
      ST_DRAIN: if (acc_empty && !vld_q) state_d = ST_ENDED;
      ST_ENDED: state_d = ST_ENDED;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        buf_q <= acc_buf;
        cnt_q <= acc_count;
        vld_q <= 1'b1;
      end else if (vld_q && pkt_ready) begin
        buf_q <= '0;
        cnt_q <= '0;
        vld_q <= 1'b0;
      end
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign pkt_valid      = vld_q;
  assign overflow       = ovf_q;
  assign test_ending    = (state_q == ST_DRAIN);
  assign test_has_ended = (state_q == ST_ENDED);

endmodule

// File: doc/projcalculadoranios_nios2_qsys_0_oci_dct_packer.md
PROJCALCULADORANIOS_NIOS2_QSYS_0_OCI_DCT_PACKER -- requirements
Module: projcalculadoranios_nios2_qsys_0_oci_dct_packer

Interface
REQ-001 SHALL have parameter DCT_SLOTS, default 15, giving the number of 2-bit codes per packet.
REQ-002 SHALL have parameter CODE_W, default 2, giving the width of one branch-outcome code.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port trc_on, input, 1, trace enable; codes are accepted only while high.
REQ-006 SHALL have port dct_valid, input, 1, qualifies dct_code this cycle.
REQ-007 SHALL have port dct_code, input, 2, branch outcome code: 01 not-taken, 10 taken, 11 indirect, 00 reserved.
REQ-008 SHALL have port end_req, input, 1, one-cycle pulse requesting end-of-test drain.
REQ-009 SHALL have port pkt_ready, input, 1, downstream consumer accepts the packet.
REQ-010 SHALL have port dct_buffer, output, 30, packed codes with slot k at bits [2k+1:2k].
REQ-011 SHALL have port dct_count, output, 4, number of valid slots in dct_buffer (1..15).
REQ-012 SHALL have port pkt_valid, output, 1, dct_buffer/dct_count hold a packet.
REQ-013 SHALL have port overflow, output, 1, sticky flag: a code was dropped.
REQ-014 SHALL have ports test_ending and test_has_ended, outputs, 1 each, end-of-test status.

Function
REQ-015 SHALL hold an accumulator (30-bit buffer, 4-bit count) plus a one-entry output register driving dct_buffer/dct_count.
REQ-016 SHALL write an accepted code into accumulator slot acc_count and increment acc_count the same edge.
REQ-017 SHALL accept a code when dct_valid=1, trc_on=1, state RUN, dct_code!=00, and accumulator not full-and-blocked.
REQ-018 SHALL silently ignore code 00 without setting overflow.
REQ-019 SHALL transfer the accumulator to the output register when acc_count=15 and the output register is empty or is being emptied (pkt_valid&pkt_ready) that cycle.
REQ-020 SHALL, on a transfer cycle coinciding with an accepted code, place the new code in slot 0 of the cleared accumulator (acc_count=1).
REQ-021 SHALL give latency of one cycle: the 15th code accepted at edge N yields pkt_valid=1 after edge N+1.
REQ-022 SHALL hold dct_buffer, dct_count stable while pkt_valid=1 and pkt_ready=0.
REQ-023 SHALL drop the code and set overflow when acc_count=15 and the output register cannot accept a transfer; overflow clears only on reset.
REQ-024 SHALL zero unused slots of dct_buffer above dct_count.
REQ-025 SHALL implement states IDLE, RUN, DRAIN, ENDED.
REQ-026 SHALL go IDLE->RUN when trc_on=1; RUN->IDLE when trc_on=0 (accumulator retained).
REQ-027 SHALL go IDLE or RUN->DRAIN on end_req; end_req in DRAIN or ENDED is ignored.
REQ-028 SHALL, in DRAIN, accept no codes and transfer a partial accumulator (acc_count 1..14) to the output register when it is free.
REQ-029 SHALL go DRAIN->ENDED when acc_count=0 and pkt_valid=0; ENDED holds until reset.
REQ-030 SHALL drive test_ending=1 exactly while in DRAIN, and test_has_ended=1 exactly while in ENDED.

Reset
REQ-031 SHALL on reset set state IDLE, accumulator empty, dct_buffer=0, dct_count=0, pkt_valid=0, overflow=0, test_ending=0, test_has_ended=0.
REQ-032 SHALL let reset override all other inputs, including mid-packet and during DRAIN; partial data is discarded.

Structure
REQ-033 SHALL place DCT_SLOTS, CODE_W, code encodings, and the state encoding in shared package projcalculadoranios_nios2_qsys_0_oci_pkg.
REQ-034 SHALL isolate the accumulator (slot write, count, clear-and-load) in one sub-module projcalculadoranios_nios2_qsys_0_oci_dct_accum.

Verification
REQ-035 SHALL cover: trc_on=1, 15 codes 10, pkt_ready=1 -> one packet dct_buffer=0x2AAAAAAA, dct_count=15, pkt_valid high one cycle.
REQ-036 SHALL cover: 30 back-to-back codes 01, pkt_ready=0 until code 30 -> first packet 0x15555555 held stable, 15 codes waiting in accumulator, overflow=0; code 31 -> overflow=1.
REQ-037 SHALL cover: 15th code with pkt_valid&pkt_ready simultaneous plus 16th code same cycle -> new packet loaded, acc_count=1, slot 0=16th code.
REQ-038 SHALL cover: 3 codes 11, end_req -> test_ending=1, packet dct_buffer=0x3F, dct_count=3, then test_has_ended=1 after acceptance.
REQ-039 SHALL cover: reset asserted in DRAIN with pkt_valid=1 -> all outputs 0 next cycle, state IDLE.
REQ-040 SHALL cover: codes 00 and codes with trc_on=0 -> no slot consumed, overflow=0.
